// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: hands one MULT/DIV at a time to the multi-cycle units and strobes HI/LO on completion
module muldiv_sequencer #(
    parameter int DATA_W = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              req_ready,
    output logic              busy,
    output logic              mult_start,
    output logic              div_start,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              mult_done_in,
    input  logic [DATA_W-1:0] mult_hi,
    input  logic [DATA_W-1:0] mult_lo,
    input  logic              div_done_in,
    input  logic [DATA_W-1:0] div_rem,
    input  logic [DATA_W-1:0] div_quot,
    output logic              HIWrite,
    output logic              LOWrite,
    output logic [DATA_W-1:0] hi_data,
    output logic [DATA_W-1:0] lo_data,
    output logic              div_zero,
    output logic              bad_op,
    output logic              timeout,
    output logic              op_done
);
    typedef enum logic [1:0] {IDLE, START, WAIT, WRITE} state_t;
    state_t state, state_n;
    logic is_div, is_div_n, wr, wr_n, done_sel;
    logic mult_start_n, div_start_n, div_zero_n, bad_op_n, timeout_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] op_a_n, op_b_n, hi_n, lo_n;

    assign HIWrite = wr;
    assign LOWrite = wr;
    assign op_done = wr;
    assign done_sel = is_div ? div_done_in : mult_done_in;

    // Every output is a register; next values are formed here and loaded below
    always_comb begin
        state_n = state;
        is_div_n = is_div;
        cnt_n = cnt;
        op_a_n = op_a;
        op_b_n = op_b;
        hi_n = hi_data;
        lo_n = lo_data;
        mult_start_n = 1'b0;
        div_start_n = 1'b0;
        wr_n = 1'b0;
        div_zero_n = 1'b0;
        bad_op_n = 1'b0;
        timeout_n = 1'b0;
        case (state)
            IDLE: if (req_valid && req_ready) begin
                if (req_op[1]) bad_op_n = 1'b1;
                else if (req_op[0] && rt_val == '0) div_zero_n = 1'b1;
                else begin
                    op_a_n = rs_val;
                    op_b_n = rt_val;
                    is_div_n = req_op[0];
                    mult_start_n = !req_op[0];
                    div_start_n = req_op[0];
                    state_n = START;
                end
            end
            START: begin
                cnt_n = '0;
                state_n = WAIT;
            end
            WAIT: if (done_sel) begin
                hi_n = is_div ? div_rem : mult_hi;
                lo_n = is_div ? div_quot : mult_lo;
                wr_n = 1'b1;
                state_n = WRITE;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_n = 1'b1;
                state_n = IDLE;
            end else cnt_n = cnt + 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            is_div <= 1'b0;
            cnt <= '0;
            op_a <= '0;
            op_b <= '0;
            hi_data <= '0;
            lo_data <= '0;
            req_ready <= 1'b1;
            busy <= 1'b0;
            mult_start <= 1'b0;
            div_start <= 1'b0;
            wr <= 1'b0;
            div_zero <= 1'b0;
            bad_op <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_n;
            is_div <= is_div_n;
            cnt <= cnt_n;
            op_a <= op_a_n;
            op_b <= op_b_n;
            hi_data <= hi_n;
            lo_data <= lo_n;
            req_ready <= state_n == IDLE;
            busy <= state_n != IDLE;
            mult_start <= mult_start_n;
            div_start <= div_start_n;
            wr <= wr_n;
            div_zero <= div_zero_n;
            bad_op <= bad_op_n;
            timeout <= timeout_n;
        end
    end
endmodule
